// File: rtl/hot_vector_serializer.sv
// hot_vector_serializer
// Captures a WIDTH-bit hot vector and emits the index of each set bit, one
// per output handshake, either lowest-first or highest-first. out_last_o
// marks the final set bit. A one-cycle empty_o pulse flags an all-zero vector.
module hot_vector_serializer #(
    parameter int unsigned WIDTH     = 13,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] in_vector_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             empty_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   residual, res_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               last_nxt;
    logic               empty_nxt;

    // Next residual and state. The index and last flag are precomputed from
    // the next residual so that both outputs come straight from registers.
    always_comb begin
        state_nxt = state;
        res_nxt   = residual;
        empty_nxt = 1'b0;
        if (flush_i) begin
            state_nxt = IDLE;
            res_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        res_nxt   = in_vector_i;
                        empty_nxt = (in_vector_i == '0);
                        state_nxt = (in_vector_i == '0) ? IDLE : BUSY;
                    end
                end
                BUSY: begin
                    if (out_ready_i) begin
                        res_nxt[out_idx_o] = 1'b0;
                        state_nxt = out_last_o ? IDLE : BUSY;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    res_nxt   = '0;
                end
            endcase
        end
    end

    // Priority-select the next index: the later match wins, so the scan
    // direction is reversed relative to the emission order.
    always_comb begin
        idx_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (res_nxt[i]) idx_nxt = IDX_W'(i);
            end else begin
                if (res_nxt[WIDTH-1-i]) idx_nxt = IDX_W'(WIDTH - 1 - i);
            end
        end
        last_nxt = (res_nxt != '0) && ((res_nxt & (res_nxt - WIDTH'(1))) == '0);
    end

    // State, residual vector and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            residual   <= '0;
            out_idx_o  <= '0;
            out_last_o <= 1'b0;
            empty_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            residual   <= res_nxt;
            out_idx_o  <= idx_nxt;
            out_last_o <= last_nxt;
            empty_o    <= empty_nxt;
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == BUSY);

endmodule

// File: tb/tb_hot_vector_serializer.sv
// tb_hot_vector_serializer
// Drives an LSB-first and an MSB-first instance (WIDTH=13) from shared
// stimulus and compares against index sequences built from each vector.
module tb_hot_vector_serializer;

    localparam int unsigned W  = 13;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [W-1:0]  vec;
    logic          in_valid;
    logic          out_ready;

    logic          rdy_l, val_l, last_l, empty_l;
    logic [IW-1:0] idx_l;
    logic          rdy_m, val_m, last_m, empty_m;
    logic [IW-1:0] idx_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hot_vector_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_vector_i(vec), .in_valid_i(in_valid), .in_ready_o(rdy_l),
        .out_idx_o(idx_l), .out_valid_o(val_l), .out_ready_i(out_ready),
        .out_last_o(last_l), .empty_o(empty_l)
    );

    hot_vector_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_vector_i(vec), .in_valid_i(in_valid), .in_ready_o(rdy_m),
        .out_idx_o(idx_m), .out_valid_o(val_m), .out_ready_i(out_ready),
        .out_last_o(last_m), .empty_o(empty_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready_l"}, 32'(rdy_l), 32'd1);
        check({tag, " in_ready_m"}, 32'(rdy_m), 32'd1);
        check({tag, " valid_l"},    32'(val_l), 32'd0);
        check({tag, " valid_m"},    32'(val_m), 32'd0);
    endtask

    // Present a vector for one edge; the caller is already in IDLE.
    task automatic send(input logic [W-1:0] v);
        check("send ready", 32'(rdy_l & rdy_m), 32'd1);
        vec      = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vec      = '0;
    endtask

    // Send a vector and drain it; stall bit c drops out_ready in cycle c.
    task automatic run_burst(input string tag, input logic [W-1:0] v, input logic [31:0] stall);
        logic [IW-1:0] exp_l[W];
        logic [IW-1:0] exp_m[W];
        int pop = 0;
        int beats = 0;
        int cyc = 0;
        int stalls = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (v[i]) begin
                exp_l[pop] = IW'(i);
                pop++;
            end
        end
        for (int i = 0; i < pop; i++) exp_m[i] = exp_l[pop-1-i];
        send(v);
        while (beats < pop && cyc < 64) begin
            out_ready = (cyc < 32) ? ~stall[cyc] : 1'b1;
            check({tag, " valid"},    32'(val_l & val_m), 32'd1);
            check({tag, " in_ready"}, 32'(rdy_l | rdy_m), 32'd0);
            check({tag, " idx_l"},    32'(idx_l), 32'(exp_l[beats]));
            check({tag, " idx_m"},    32'(idx_m), 32'(exp_m[beats]));
            check({tag, " last_l"},   32'(last_l), 32'(beats == pop - 1));
            check({tag, " last_m"},   32'(last_m), 32'(beats == pop - 1));
            if (out_ready) beats++;
            else stalls++;
            step();
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, " beats"},  32'(beats), 32'(pop));
        check({tag, " cycles"}, 32'(cyc), 32'(pop + stalls));
        check_idle({tag, " end"});
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        vec       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst idx_l",   32'(idx_l), 32'd0);
        check("rst last_l",  32'(last_l), 32'd0);
        check("rst empty_l", 32'(empty_l), 32'd0);
        check_idle("rst");
        rst_n = 1'b1;
        step();

        // ascending/descending order, no stalls
        run_burst("t1", 13'h1025, 32'h0);

        // out_ready low for three cycles while index 2 is presented
        run_burst("t3", 13'h1025, 32'hE);

        // all-zero vector: one-cycle empty pulse, never busy
        send('0);
        check("t4 empty_l", 32'(empty_l), 32'd1);
        check("t4 empty_m", 32'(empty_m), 32'd1);
        check_idle("t4 zero");
        step();
        check("t4 empty_l off", 32'(empty_l), 32'd0);
        check_idle("t4 zero+1");

        // full vector: 13 back-to-back beats
        run_burst("t4 full", 13'h1FFF, 32'h0);

        // flush during the second beat
        send(13'h1025);
        check("t5 idx0", 32'(idx_l), 32'd0);
        step();
        check("t5 idx2 l", 32'(idx_l), 32'd2);
        check("t5 idx2 m", 32'(idx_m), 32'd5);
        check("t5 valid",  32'(val_l), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        vec      = 13'h0003;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("t5 flushed");
        check("t5 idx_l zero",  32'(idx_l), 32'd0);
        check("t5 last_l zero", 32'(last_l), 32'd0);
        step();
        check_idle("t5 flushed+1");

        // flush in IDLE blocks capture of a simultaneous vector
        flush    = 1'b1;
        in_valid = 1'b1;
        vec      = 13'h0007;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("t5 idle flush");
        check("t5 idle flush empty", 32'(empty_l), 32'd0);
        run_burst("t5 after flush", 13'h0090, 32'h1);

        // asynchronous reset mid-burst
        send(13'h1025);
        check("t5r valid", 32'(val_l), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t5r async");
        check("t5r idx_m",  32'(idx_m), 32'd0);
        check("t5r last_l", 32'(last_l), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_idle("t5r released");

        // directed edge vectors plus a few random ones under random stalls
        run_burst("t6 bit0",  13'h0001, 32'h0);
        run_burst("t6 bit12", 13'h1000, 32'h3);
        run_burst("t6 ends",  13'h1001, 32'h5);
        for (int n = 0; n < 8; n++) begin
            run_burst("t6 rnd", W'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
